graphics_cmd_master: RTL and testbench

GRAPHICS_CMD_MASTER -- requirements
Module: graphics_cmd_master

---
 rtl/graphics_cmd_master_if.sv | 38 +++
 rtl/graphics_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_graphics_cmd_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/graphics_cmd_master_if.sv
// Bus/handshake bundle between the graphics command master and its environment.
// master modport : view taken by graphics_cmd_master (drives the bus, reads operands).
// slave modport  : view taken by the requester/graphics-controller side.
// Signals: Req_H, X1/Y1/X2/Y2/Colour/Command (request + operands), Busy_H/Done_H/Err_H
// (status), AddressOut/DataOutToGraphics/DataInFromGraphics, GraphicsCS_L/AS_L/UDS_L/LDS_L/RW
// (68k-style asynchronous bus).
interface graphics_cmd_master_if;
   logic        Req_H;
   logic [15:0] X1;
   logic [15:0] Y1;
   logic [15:0] X2;
   logic [15:0] Y2;
   logic [15:0] Colour;
   logic [15:0] Command;
   logic        Busy_H;
   logic        Done_H;
   logic        Err_H;
   logic [15:0] AddressOut;
   logic [15:0] DataOutToGraphics;
   logic [15:0] DataInFromGraphics;
   logic        GraphicsCS_L;
   logic        AS_L;
   logic        UDS_L;
   logic        LDS_L;
   logic        RW;

   modport master (
      input  Req_H, X1, Y1, X2, Y2, Colour, Command, DataInFromGraphics,
      output Busy_H, Done_H, Err_H, AddressOut, DataOutToGraphics,
             GraphicsCS_L, AS_L, UDS_L, LDS_L, RW
   );

   modport slave (
      output Req_H, X1, Y1, X2, Y2, Colour, Command, DataInFromGraphics,
      input  Busy_H, Done_H, Err_H, AddressOut, DataOutToGraphics,
             GraphicsCS_L, AS_L, UDS_L, LDS_L, RW
   );
endinterface

// File: rtl/graphics_cmd_master.sv
// Graphics command master: on a request it polls the graphics controller status register
// until bit0 reports idle (or POLL_LIMIT busy reads elapse), then writes X1, Y1, X2, Y2,
// Colour and finally Command as six three-phase bus cycles (setup / strobe / release).
// Ports:
//   Clk   - single clock, all state changes on the rising edge
//   Reset - asynchronous active-high reset
//   bus   - graphics_cmd_master_if.master (request, operands, status, bus signals)
// Every output is a register, loaded with the value belonging to the state being entered.
module graphics_cmd_master #(
   parameter logic [15:0] BASE_ADDR  = 16'h0000,
   parameter int          POLL_LIMIT = 1023
) (
   input  logic                  Clk,
   input  logic                  Reset,
   graphics_cmd_master_if.master bus
);

   localparam int CNT_W = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      POLL_SETUP,
      POLL_STROBE,
      POLL_CHECK,
      WR_SETUP,
      WR_STROBE,
      WR_RELEASE,
      DONE
   } state_t;

   state_t             state;
   logic [15:0]        x1_lat, y1_lat, x2_lat, y2_lat, colour_lat, command_lat;
   logic [2:0]         wr_idx;
   logic [CNT_W-1:0]   poll_cnt;
   logic               status_idle;

   // Register map order of the six writes; Command goes last to the base register.
   function automatic logic [15:0] wr_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    return BASE_ADDR + 16'h0002;
         3'd1:    return BASE_ADDR + 16'h0004;
         3'd2:    return BASE_ADDR + 16'h0006;
         3'd3:    return BASE_ADDR + 16'h0008;
         3'd4:    return BASE_ADDR + 16'h000E;
         default: return BASE_ADDR;
      endcase
   endfunction

   function automatic logic [15:0] wr_data(input logic [2:0] idx);
      case (idx)
         3'd0:    return x1_lat;
         3'd1:    return y1_lat;
         3'd2:    return x2_lat;
         3'd3:    return y2_lat;
         3'd4:    return colour_lat;
         default: return command_lat;
      endcase
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state                 <= IDLE;
         x1_lat                <= '0;
         y1_lat                <= '0;
         x2_lat                <= '0;
         y2_lat                <= '0;
         colour_lat            <= '0;
         command_lat           <= '0;
         wr_idx                <= '0;
         poll_cnt              <= '0;
         status_idle           <= 1'b0;
         bus.Busy_H            <= 1'b0;
         bus.Done_H            <= 1'b0;
         bus.Err_H             <= 1'b0;
         bus.AddressOut        <= '0;
         bus.DataOutToGraphics <= '0;
         bus.GraphicsCS_L      <= 1'b1;
         bus.AS_L              <= 1'b1;
         bus.UDS_L             <= 1'b1;
         bus.LDS_L             <= 1'b1;
         bus.RW                <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Req_H) begin
                  // Operands are frozen here; later input changes cannot reach the bus.
                  x1_lat           <= bus.X1;
                  y1_lat           <= bus.Y1;
                  x2_lat           <= bus.X2;
                  y2_lat           <= bus.Y2;
                  colour_lat       <= bus.Colour;
                  command_lat      <= bus.Command;
                  poll_cnt         <= '0;
                  state            <= POLL_SETUP;
                  bus.Busy_H       <= 1'b1;
                  bus.GraphicsCS_L <= 1'b0;
                  bus.RW           <= 1'b1;
                  bus.AddressOut   <= BASE_ADDR;
               end
            end

            POLL_SETUP: begin
               state     <= POLL_STROBE;
               bus.AS_L  <= 1'b0;
               bus.UDS_L <= 1'b0;
               bus.LDS_L <= 1'b0;
            end

            POLL_STROBE: begin
               status_idle <= bus.DataInFromGraphics[0];
               state       <= POLL_CHECK;
               bus.AS_L    <= 1'b1;
               bus.UDS_L   <= 1'b1;
               bus.LDS_L   <= 1'b1;
            end

            POLL_CHECK: begin
               if (status_idle) begin
                  wr_idx                <= 3'd0;
                  state                 <= WR_SETUP;
                  bus.RW                <= 1'b0;
                  bus.AddressOut        <= wr_addr(3'd0);
                  bus.DataOutToGraphics <= wr_data(3'd0);
               end else if (poll_cnt == CNT_W'(POLL_LIMIT - 1)) begin
                  // Controller never went idle: finish without writing anything.
                  state                 <= DONE;
                  bus.Busy_H            <= 1'b0;
                  bus.Done_H            <= 1'b1;
                  bus.Err_H             <= 1'b1;
                  bus.GraphicsCS_L      <= 1'b1;
                  bus.RW                <= 1'b1;
                  bus.AddressOut        <= '0;
                  bus.DataOutToGraphics <= '0;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                  state    <= POLL_SETUP;
               end
            end

            WR_SETUP: begin
               state     <= WR_STROBE;
               bus.AS_L  <= 1'b0;
               bus.UDS_L <= 1'b0;
               bus.LDS_L <= 1'b0;
            end

            WR_STROBE: begin
               state     <= WR_RELEASE;
               bus.AS_L  <= 1'b1;
               bus.UDS_L <= 1'b1;
               bus.LDS_L <= 1'b1;
            end

            WR_RELEASE: begin
               if (wr_idx == 3'd5) begin
                  state                 <= DONE;
                  bus.Busy_H            <= 1'b0;
                  bus.Done_H            <= 1'b1;
                  bus.Err_H             <= 1'b0;
                  bus.GraphicsCS_L      <= 1'b1;
                  bus.RW                <= 1'b1;
                  bus.AddressOut        <= '0;
                  bus.DataOutToGraphics <= '0;
               end else begin
                  // Address and data change only at the release->setup boundary.
                  wr_idx                <= wr_idx + 3'd1;
                  state                 <= WR_SETUP;
                  bus.AddressOut        <= wr_addr(wr_idx + 3'd1);
                  bus.DataOutToGraphics <= wr_data(wr_idx + 3'd1);
               end
            end

            DONE: begin
               state      <= IDLE;
               bus.Done_H <= 1'b0;
               bus.Err_H  <= 1'b0;
            end

            default: begin
               state            <= IDLE;
               bus.Busy_H       <= 1'b0;
               bus.Done_H       <= 1'b0;
               bus.Err_H        <= 1'b0;
               bus.GraphicsCS_L <= 1'b1;
               bus.AS_L         <= 1'b1;
               bus.UDS_L        <= 1'b1;
               bus.LDS_L        <= 1'b1;
               bus.RW           <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_graphics_cmd_master.sv
// Directed bench for graphics_cmd_master: a default-timeout instance at BASE_ADDR 16'h4000
// and a second instance with POLL_LIMIT=4 whose status input is held busy.
module tb_graphics_cmd_master;

   logic Clk;
   logic Reset;

   graphics_cmd_master_if gif();
   graphics_cmd_master_if gif2();

   graphics_cmd_master #(.BASE_ADDR(16'h4000)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (gif.master)
   );

   graphics_cmd_master #(.POLL_LIMIT(4)) dut_to (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (gif2.master)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int vectors     = 0;
   int miscompares = 0;

   // Bus observer / status responder for the main instance.
   int          busy_reads   = 0;
   int          rd_in_txn    = 0;
   int          rd_total     = 0;
   int          bcnt         = 0;
   int          first_wr     = 0;
   bit          wr_started   = 1'b0;
   int          strobe_total = 0;
   int          done_total   = 0;
   logic [15:0] wa_q[$];
   logic [15:0] wd_q[$];

   always @(negedge Clk) begin
      if (!gif.Busy_H) begin
         bcnt       <= 0;
         wr_started <= 1'b0;
         rd_in_txn  <= 0;
      end else begin
         bcnt <= bcnt + 1;
      end
      if (gif.Busy_H && !gif.RW && !wr_started) begin
         first_wr   <= bcnt + 1;
         wr_started <= 1'b1;
      end
      if (!gif.AS_L) strobe_total <= strobe_total + 1;
      if (!gif.AS_L && gif.RW) begin
         gif.DataInFromGraphics <= (rd_in_txn >= busy_reads) ? 16'h0001 : 16'h0000;
         rd_in_txn <= rd_in_txn + 1;
         rd_total  <= rd_total + 1;
      end
      if (!gif.AS_L && !gif.RW) begin
         wa_q.push_back(gif.AddressOut);
         wd_q.push_back(gif.DataOutToGraphics);
      end
      if (gif.Done_H) done_total <= done_total + 1;
   end

   // Observer for the timeout instance; its controller never reports idle.
   int rd2_total = 0;
   int wr2_total = 0;
   assign gif2.DataInFromGraphics = 16'h0000;

   always @(negedge Clk) begin
      if (!gif2.AS_L && gif2.RW) rd2_total <= rd2_total + 1;
      if (gif2.Busy_H && !gif2.RW) wr2_total <= wr2_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counts negedges after the accept edge until Done_H is seen (bounded by limit).
   task automatic wait_done(input int limit, input bit drop_req, output int n);
      n = 0;
      do begin
         @(negedge Clk);
         n++;
         if (drop_req && n == 1) gif.Req_H = 1'b0;
      end while (!gif.Done_H && n < limit);
   endtask

   task automatic set_ops(input logic [15:0] x1, input logic [15:0] y1, input logic [15:0] x2,
                          input logic [15:0] y2, input logic [15:0] col, input logic [15:0] cmd);
      gif.X1      = x1;
      gif.Y1      = y1;
      gif.X2      = x2;
      gif.Y2      = y2;
      gif.Colour  = col;
      gif.Command = cmd;
   endtask

   task automatic check_writes(input string tag, input int base, input logic [15:0] d [6]);
      logic [15:0] ea [6];
      ea = '{16'h4002, 16'h4004, 16'h4006, 16'h4008, 16'h400E, 16'h4000};
      check({tag, "_wr_count"}, 32'(wa_q.size() - base), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("%s_wr%0d_addr", tag, i), {16'h0, (base + i < wa_q.size()) ? wa_q[base + i] : 16'hDEAD}, {16'h0, ea[i]});
         check($sformatf("%s_wr%0d_data", tag, i), {16'h0, (base + i < wd_q.size()) ? wd_q[base + i] : 16'hDEAD}, {16'h0, d[i]});
      end
   endtask

   initial begin
      int          n;
      int          base;
      int          rd0;
      int          s0;
      int          d0;
      logic [15:0] exp_d [6];

      Reset     = 1'b1;
      gif.Req_H  = 1'b0;
      gif2.Req_H = 1'b0;
      set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      gif2.X1 = 16'h0; gif2.Y1 = 16'h0; gif2.X2 = 16'h0;
      gif2.Y2 = 16'h0; gif2.Colour = 16'h0; gif2.Command = 16'h0;
      repeat (3) @(negedge Clk);

      // Reset state
      check("rst_busy", {31'h0, gif.Busy_H}, 32'd0);
      check("rst_done_err", {30'h0, gif.Done_H, gif.Err_H}, 32'd0);
      check("rst_strobes", {28'h0, gif.GraphicsCS_L, gif.AS_L, gif.UDS_L, gif.LDS_L}, 32'hF);
      check("rst_rw", {31'h0, gif.RW}, 32'd1);
      check("rst_addr_data", {gif.AddressOut, gif.DataOutToGraphics}, 32'd0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      check("idle_bus", {27'h0, gif.GraphicsCS_L, gif.AS_L, gif.UDS_L, gif.LDS_L, gif.RW}, 32'h1F);

      // Immediate-idle transaction
      base = wa_q.size();
      rd0  = rd_total;
      busy_reads = 0;
      set_ops(16'd0, 16'd0, 16'd800, 16'd500, 16'd5, 16'd3);
      gif.Req_H = 1'b1;
      wait_done(60, 1'b1, n);
      check("t1_done_cycle", n, 32'd22);
      check("t1_err", {31'h0, gif.Err_H}, 32'd0);
      check("t1_busy_in_done", {31'h0, gif.Busy_H}, 32'd0);
      check("t1_reads", rd_total - rd0, 32'd1);
      check("t1_first_wr_cycle", first_wr, 32'd4);
      exp_d = '{16'd0, 16'd0, 16'd800, 16'd500, 16'd5, 16'd3};
      check_writes("t1", base, exp_d);
      @(negedge Clk);
      check("t1_done_pulse_end", {30'h0, gif.Done_H, gif.Busy_H}, 32'd0);

      // Four busy status reads before idle
      base = wa_q.size();
      rd0  = rd_total;
      busy_reads = 4;
      set_ops(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066);
      gif.Req_H = 1'b1;
      wait_done(80, 1'b1, n);
      check("t2_done_cycle", n, 32'd34);
      check("t2_reads", rd_total - rd0, 32'd5);
      check("t2_first_wr_cycle", first_wr, 32'd16);
      exp_d = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
      check_writes("t2", base, exp_d);
      busy_reads = 0;
      @(negedge Clk);

      // Timeout instance, POLL_LIMIT=4
      gif2.Req_H = 1'b1;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
         if (n == 1) gif2.Req_H = 1'b0;
      end while (!gif2.Done_H && n < 60);
      check("to_done_cycle", n, 32'd13);
      check("to_done_err", {30'h0, gif2.Done_H, gif2.Err_H}, 32'h3);
      check("to_reads", rd2_total, 32'd4);
      check("to_writes", wr2_total, 32'd0);
      @(negedge Clk);
      check("to_pulse_end", {30'h0, gif2.Done_H, gif2.Err_H}, 32'd0);

      // Reset during WR_STROBE of index 2
      set_ops(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606);
      gif.Req_H = 1'b1;
      @(negedge Clk);
      gif.Req_H = 1'b0;
      n = 0;
      while (!(!gif.AS_L && !gif.RW && gif.AddressOut == 16'h4006) && n < 40) begin
         @(negedge Clk);
         n++;
      end
      check("rs_reached_strobe2", {31'h0, n < 40}, 32'd1);
      #1 Reset = 1'b1;
      #1;
      check("rs_async_strobes", {28'h0, gif.GraphicsCS_L, gif.AS_L, gif.UDS_L, gif.LDS_L}, 32'hF);
      check("rs_async_busy_rw", {30'h0, gif.Busy_H, gif.RW}, 32'd1);
      check("rs_async_addr", {16'h0, gif.AddressOut}, 32'd0);
      s0 = strobe_total;
      d0 = done_total;
      @(negedge Clk);
      Reset = 1'b0;
      repeat (30) @(negedge Clk);
      check("rs_no_strobes", strobe_total - s0, 32'd0);
      check("rs_no_done", done_total - d0, 32'd0);
      check("rs_idle_cs", {30'h0, gif.GraphicsCS_L, gif.Busy_H}, 32'h2);

      // Req_H held high, operands changed mid-transaction
      base = wa_q.size();
      set_ops(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0007);
      gif.Req_H = 1'b1;
      repeat (3) @(negedge Clk);
      set_ops(16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 16'hE5E5, 16'h0009);
      wait_done(60, 1'b0, n);
      check("hold_done_cycle", n + 3, 32'd22);
      exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0007};
      check_writes("hold", base, exp_d);
      @(negedge Clk);
      check("hold_idle_after_done", {31'h0, gif.Busy_H}, 32'd0);
      @(negedge Clk);
      check("hold_reaccept", {31'h0, gif.Busy_H}, 32'd1);
      gif.Req_H = 1'b0;
      base = wa_q.size();
      wait_done(60, 1'b0, n);
      check("hold2_done_cycle", n + 1, 32'd22);
      exp_d = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 16'hE5E5, 16'h0009};
      check_writes("hold2", base, exp_d);
      repeat (3) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
